instruction_decoder_pipe: RTL and testbench
===========================================

// Module: instruction_decoder_pipe
// PURPOSE
//  Registered MIPS decode stage between fetch and execute. Decodes one 32-bit instruction per
//  accepted input beat into a TYPE_W-bit one-hot class vector plus extracted operand fields.
//  Results are buffered in a DEPTH-entry FIFO with valid/ready on both sides.
//  Flags and counts illegal encodings, and captures the PC of the first illegal encoding.
// PARAMETERS
//  DEPTH   2   output FIFO entries (>=1; power of two not required)
//  TYPE_W  40  one-hot class width (>=31; >=39 when ID_EXT_EN is defined)
//  CNT_W   16  illegal-instruction counter width (saturating)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       instruction beat valid
//  in_ready   out  1       stage can accept; registered, = (count < DEPTH)
//  in_instr   in   32      instruction word
//  in_pc      in   32      PC of the instruction
//  out_valid  out  1       FIFO head valid (count != 0)
//  out_ready  in   1       consumer accepts head
//  out_type   out  TYPE_W  one-hot class; all-zero for an illegal encoding
//  out_rs     out  5       instr[25:21]
//  out_rt     out  5       instr[20:16]
//  out_rd     out  5       instr[15:11]
//  out_shamt  out  5       instr[10:6]
//  out_wreg   out  5       destination register; 0 = no write
//  out_imm    out  32      extended immediate / jump target
//  out_pc     out  32      PC carried through
//  out_ill    out  1       head entry is an illegal encoding
//  ill_cnt    out  CNT_W   illegal beats accepted, saturating at all-ones
//  ill_pc     out  32      PC of the first illegal beat since reset or clear
//  ill_seen   out  1       sticky: ill_pc holds a captured value
//  ill_clr    in   1       clears ill_cnt, ill_seen and ill_pc on the next edge
// BEHAVIOUR
//  - Reset: count=0, pointers=0, in_ready=1, out_valid=0, ill_cnt=0, ill_seen=0, ill_pc=0.
//    Head fields read 0 while empty.
//  - Reset mid-stream: all buffered entries are discarded. There is no drain.
//  - Push when in_valid&in_ready; pop when out_valid&out_ready. Push and pop in the same cycle
//    are both honoured, and count is unchanged.
//  - When full, in_ready=0 even if a pop occurs this cycle. There is no combinational
//    ready path.
//  - Latency: an input accepted at edge N into an empty FIFO is visible on the head after edge N.
//  - Class codes, {op,func} -> bit. These are R-type only (op=0):
//    - ADD=0, ADDU=1, SUB=2, SUBU=3, AND=4, OR=5, XOR=6, NOR=7, SLT=8, SLTU=9,
//    - SLL=10, SRL=11, SRA=12, SLLV=13, SRLV=14, SRAV=15, JR=16.
//  - Class codes by op only:
//    - ADDI=17, ADDIU=18, ANDI=19, ORI=20, XORI=21, LUI=22, LW=23, SW=24, BEQ=25, BNE=26,
//    - SLTI=27, SLTIU=28, J=29, JAL=30.
//  - Any other encoding: out_type=0 and out_ill=1. The all-zero word decodes as SLL (NOP).
//  - out_wreg:
//    - R-type ALU and shift classes: rd.
//    - ADDI..LUI, SLTI, SLTIU, LW: rt.
//    - JAL: 31.
//    - JR, SW, BEQ, BNE, J, illegal: 0.
//  - out_imm:
//    - ANDI, ORI, XORI: zero-extended imm16.
//    - LUI: {imm16,16'h0}.
//    - J, JAL: {in_pc[31:28],instr[25:0],2'b00}.
//    - All others: sign-extended imm16.
//  - ill_cnt increments once per accepted illegal beat and saturates at all-ones.
//    - The first accepted illegal beat with ill_seen=0 latches ill_pc and sets ill_seen.
//    - ill_clr has priority over a same-cycle increment and capture: the result is cnt=0,
//      seen=0.
// CONFIGURATION
//  - ID_EXT_EN defined: additionally decode MULT=31, MULTU=32, DIV=33, DIVU=34, MFHI=35,
//    MFLO=36, MTHI=37, MTLO=38 (op=0, func 0x18,19,1A,1B,10,12,11,13).
//    - out_wreg = rd for MFHI and MFLO, else 0.
//  - ID_EXT_EN not defined: those encodings are illegal, and bits 31..TYPE_W-1 are always 0.
// STRUCTURE
//  - Package decoder_pkg:
//    - Class bit-index localparams (T_ADD..T_JAL, T_MULT..T_MTLO).
//    - Opcode and func localparams.
//    - REG_RA=31.
//  - Sub-module id_decode_comb:
//    - Purely combinational: instr, pc -> type, wreg, imm, ill.
//    - Instantiated once on the input side; the FIFO stores decoded results.
//  - Parent holds the FIFO storage, pointers, count and illegal bookkeeping.
// TESTING
//  1. Reset, then push 0x00851020 (ADD $2,$4,$5), out_ready=1.
//     -> next cycle out_type bit0, wreg=2, ill=0, out_pc echoed.
//  2. Push 0x3C01ABCD (LUI), then 0x3021FFFF (ANDI).
//     -> imm=0xABCD0000, then 0x0000FFFF, both with wreg=1.
//  3. out_ready=0, push 3 beats with DEPTH=2.
//     -> in_ready drops after 2 pushes, the third is held.
//     -> release: order preserved, exactly one beat per pop.
//  4. Push 0xFC000000 at pc=0x100, then 0x0000001F at pc=0x104.
//     -> both out_ill=1, type=0, ill_cnt=2, ill_pc=0x100 (first kept).
//     -> ill_clr -> cnt=0, seen=0.
//  5. With in_valid held and out_ready=1 in steady state, a new head appears every cycle
//     (full throughput).
//  6. JAL 0x0C000040 at pc=0x80000000.
//     -> type bit30, wreg=31, imm=0x80000100.
//     -> assert rst with 2 entries buffered: out_valid=0 and in_ready=1 after the edge.
//  Additional run with ID_EXT_EN: 0x00000010 (MFHI $0) -> bit35; without the macro it is illegal.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared encodings for the MIPS decode stage: class bit indices,
// opcode/func values and the decoded bundle stored in the stage FIFO.
package decoder_pkg;

    localparam logic [5:0] T_ADD   = 6'd0;
    localparam logic [5:0] T_ADDU  = 6'd1;
    localparam logic [5:0] T_SUB   = 6'd2;
    localparam logic [5:0] T_SUBU  = 6'd3;
    localparam logic [5:0] T_AND   = 6'd4;
    localparam logic [5:0] T_OR    = 6'd5;
    localparam logic [5:0] T_XOR   = 6'd6;
    localparam logic [5:0] T_NOR   = 6'd7;
    localparam logic [5:0] T_SLT   = 6'd8;
    localparam logic [5:0] T_SLTU  = 6'd9;
    localparam logic [5:0] T_SLL   = 6'd10;
    localparam logic [5:0] T_SRL   = 6'd11;
    localparam logic [5:0] T_SRA   = 6'd12;
    localparam logic [5:0] T_SLLV  = 6'd13;
    localparam logic [5:0] T_SRLV  = 6'd14;
    localparam logic [5:0] T_SRAV  = 6'd15;
    localparam logic [5:0] T_JR    = 6'd16;
    localparam logic [5:0] T_ADDI  = 6'd17;
    localparam logic [5:0] T_ADDIU = 6'd18;
    localparam logic [5:0] T_ANDI  = 6'd19;
    localparam logic [5:0] T_ORI   = 6'd20;
    localparam logic [5:0] T_XORI  = 6'd21;
    localparam logic [5:0] T_LUI   = 6'd22;
    localparam logic [5:0] T_LW    = 6'd23;
    localparam logic [5:0] T_SW    = 6'd24;
    localparam logic [5:0] T_BEQ   = 6'd25;
    localparam logic [5:0] T_BNE   = 6'd26;
    localparam logic [5:0] T_SLTI  = 6'd27;
    localparam logic [5:0] T_SLTIU = 6'd28;
    localparam logic [5:0] T_J     = 6'd29;
    localparam logic [5:0] T_JAL   = 6'd30;
    localparam logic [5:0] T_MULT  = 6'd31;
    localparam logic [5:0] T_MULTU = 6'd32;
    localparam logic [5:0] T_DIV   = 6'd33;
    localparam logic [5:0] T_DIVU  = 6'd34;
    localparam logic [5:0] T_MFHI  = 6'd35;
    localparam logic [5:0] T_MFLO  = 6'd36;
    localparam logic [5:0] T_MTHI  = 6'd37;
    localparam logic [5:0] T_MTLO  = 6'd38;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        IMM_SEXT,
        IMM_ZEXT,
        IMM_LUI,
        IMM_JMP
    } imm_sel_e;

    typedef enum logic [1:0] {
        WR_NONE,
        WR_RD,
        WR_RT,
        WR_RA
    } wreg_sel_e;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [4:0]  wreg;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } id_ex_t;

endpackage

// File: rtl/id_decode_comb.sv
// Combinational MIPS decoder: class one-hot, dest register, immediate.
// ID_EXT_EN adds the multiply/divide and HI/LO move classes.
module id_decode_comb
    import decoder_pkg::*;
#(
    parameter int TYPE_W = 40
) (
    input  logic [31:0]       instr,
    input  logic [3:0]        pc_hi,
    output logic [TYPE_W-1:0] dtype,
    output logic [4:0]        wreg,
    output logic [31:0]       imm,
    output logic              ill
);

    logic [5:0] op;
    logic [5:0] func;
    logic [5:0] cls;
    logic       hit;
    imm_sel_e   isel;
    wreg_sel_e  wsel;

    assign op   = instr[31:26];
    assign func = instr[5:0];

    always_comb begin
        cls  = '0;
        hit  = 1'b1;
        isel = IMM_SEXT;
        wsel = WR_NONE;
        if (op == OP_SPECIAL) begin
            wsel = WR_RD;
            unique case (func)
                F_ADD:   cls = T_ADD;
                F_ADDU:  cls = T_ADDU;
                F_SUB:   cls = T_SUB;
                F_SUBU:  cls = T_SUBU;
                F_AND:   cls = T_AND;
                F_OR:    cls = T_OR;
                F_XOR:   cls = T_XOR;
                F_NOR:   cls = T_NOR;
                F_SLT:   cls = T_SLT;
                F_SLTU:  cls = T_SLTU;
                F_SLL:   cls = T_SLL;
                F_SRL:   cls = T_SRL;
                F_SRA:   cls = T_SRA;
                F_SLLV:  cls = T_SLLV;
                F_SRLV:  cls = T_SRLV;
                F_SRAV:  cls = T_SRAV;
                F_JR: begin
                    cls  = T_JR;
                    wsel = WR_NONE;
                end
`ifdef ID_EXT_EN
                F_MFHI:  cls = T_MFHI;
                F_MFLO:  cls = T_MFLO;
                F_MULT: begin
                    cls  = T_MULT;
                    wsel = WR_NONE;
                end
                F_MULTU: begin
                    cls  = T_MULTU;
                    wsel = WR_NONE;
                end
                F_DIV: begin
                    cls  = T_DIV;
                    wsel = WR_NONE;
                end
                F_DIVU: begin
                    cls  = T_DIVU;
                    wsel = WR_NONE;
                end
                F_MTHI: begin
                    cls  = T_MTHI;
                    wsel = WR_NONE;
                end
                F_MTLO: begin
                    cls  = T_MTLO;
                    wsel = WR_NONE;
                end
`endif
                default: begin
                    hit  = 1'b0;
                    wsel = WR_NONE;
                end
            endcase
        end else begin
            wsel = WR_RT;
            unique case (op)
                OP_ADDI:  cls = T_ADDI;
                OP_ADDIU: cls = T_ADDIU;
                OP_SLTI:  cls = T_SLTI;
                OP_SLTIU: cls = T_SLTIU;
                OP_LW:    cls = T_LW;
                OP_ANDI: begin
                    cls  = T_ANDI;
                    isel = IMM_ZEXT;
                end
                OP_ORI: begin
                    cls  = T_ORI;
                    isel = IMM_ZEXT;
                end
                OP_XORI: begin
                    cls  = T_XORI;
                    isel = IMM_ZEXT;
                end
                OP_LUI: begin
                    cls  = T_LUI;
                    isel = IMM_LUI;
                end
                OP_SW: begin
                    cls  = T_SW;
                    wsel = WR_NONE;
                end
                OP_BEQ: begin
                    cls  = T_BEQ;
                    wsel = WR_NONE;
                end
                OP_BNE: begin
                    cls  = T_BNE;
                    wsel = WR_NONE;
                end
                OP_J: begin
                    cls  = T_J;
                    wsel = WR_NONE;
                    isel = IMM_JMP;
                end
                OP_JAL: begin
                    cls  = T_JAL;
                    wsel = WR_RA;
                    isel = IMM_JMP;
                end
                default: begin
                    hit  = 1'b0;
                    wsel = WR_NONE;
                end
            endcase
        end
    end

    always_comb begin
        unique case (wsel)
            WR_RD:   wreg = instr[15:11];
            WR_RT:   wreg = instr[20:16];
            WR_RA:   wreg = REG_RA;
            default: wreg = 5'd0;
        endcase
    end

    always_comb begin
        unique case (isel)
            IMM_ZEXT: imm = {16'h0, instr[15:0]};
            IMM_LUI:  imm = {instr[15:0], 16'h0};
            IMM_JMP:  imm = {pc_hi, instr[25:0], 2'b00};
            default:  imm = {{16{instr[15]}}, instr[15:0]};
        endcase
    end

    assign dtype = hit ? (TYPE_W'(1) << cls) : '0;
    assign ill   = ~hit;

endmodule

// File: rtl/instruction_decoder_pipe.sv
// Registered decode stage: decode on input, buffer results in a FIFO,
// track illegal encodings. ID_EXT_EN enables the mul/div/HI/LO classes.
module instruction_decoder_pipe
    import decoder_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int TYPE_W = 40,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TYPE_W-1:0] out_type,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [4:0]        out_wreg,
    output logic [31:0]       out_imm,
    output logic [31:0]       out_pc,
    output logic              out_ill,
    output logic [CNT_W-1:0]  ill_cnt,
    output logic [31:0]       ill_pc,
    output logic              ill_seen,
    input  logic              ill_clr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [TYPE_W-1:0] dec_type;
    logic [4:0]        dec_wreg;
    logic [31:0]       dec_imm;
    logic              dec_ill;
    id_ex_t            dec_f;

    logic [TYPE_W-1:0] type_mem [DEPTH];
    id_ex_t            f_mem    [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              push;
    logic              pop;
    id_ex_t            head;

    id_decode_comb #(
        .TYPE_W (TYPE_W)
    ) u_dec (
        .instr (in_instr),
        .pc_hi (in_pc[31:28]),
        .dtype (dec_type),
        .wreg  (dec_wreg),
        .imm   (dec_imm),
        .ill   (dec_ill)
    );

    assign dec_f = '{
        rs:    in_instr[25:21],
        rt:    in_instr[20:16],
        rd:    in_instr[15:11],
        shamt: in_instr[10:6],
        wreg:  dec_wreg,
        imm:   dec_imm,
        pc:    in_pc,
        ill:   dec_ill
    };

    assign push      = in_valid & in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count    <= count_nxt;
            in_ready <= (count_nxt < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            type_mem[wr_ptr] <= dec_type;
            f_mem[wr_ptr]    <= dec_f;
        end
    end

    // Storage is never cleared, so head fields are masked while empty.
    always_comb begin
        head     = '0;
        out_type = '0;
        if (out_valid) begin
            head     = f_mem[rd_ptr];
            out_type = type_mem[rd_ptr];
        end
    end

    assign out_rs    = head.rs;
    assign out_rt    = head.rt;
    assign out_rd    = head.rd;
    assign out_shamt = head.shamt;
    assign out_wreg  = head.wreg;
    assign out_imm   = head.imm;
    assign out_pc    = head.pc;
    assign out_ill   = head.ill;

    always_ff @(posedge clk) begin
        if (rst || ill_clr) begin
            ill_cnt  <= '0;
            ill_seen <= 1'b0;
            ill_pc   <= '0;
        end else if (push && dec_ill) begin
            if (ill_cnt != '1) begin
                ill_cnt <= ill_cnt + CNT_W'(1);
            end
            if (!ill_seen) begin
                ill_seen <= 1'b1;
                ill_pc   <= in_pc;
            end
        end
    end

endmodule

// File: tb/tb_instruction_decoder_pipe.sv
// Bench for instruction_decoder_pipe: table-driven decode model plus
// a queue FIFO model, directed scenarios and a randomized phase.
module tb_instruction_decoder_pipe;

    localparam int DEPTH  = 2;
    localparam int TYPE_W = 40;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              ill_clr = 1'b0;
    logic [31:0]       in_instr = '0;
    logic [31:0]       in_pc = '0;
    logic              in_ready;
    logic              out_valid;
    logic [TYPE_W-1:0] out_type;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [4:0]        out_shamt;
    logic [4:0]        out_wreg;
    logic [31:0]       out_imm;
    logic [31:0]       out_pc;
    logic              out_ill;
    logic [CNT_W-1:0]  ill_cnt;
    logic [31:0]       ill_pc;
    logic              ill_seen;

    always #5 clk = ~clk;

    instruction_decoder_pipe #(
        .DEPTH  (DEPTH),
        .TYPE_W (TYPE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_type  (out_type),
        .out_rs    (out_rs),
        .out_rt    (out_rt),
        .out_rd    (out_rd),
        .out_shamt (out_shamt),
        .out_wreg  (out_wreg),
        .out_imm   (out_imm),
        .out_pc    (out_pc),
        .out_ill   (out_ill),
        .ill_cnt   (ill_cnt),
        .ill_pc    (ill_pc),
        .ill_seen  (ill_seen),
        .ill_clr   (ill_clr)
    );

    typedef struct {
        logic [TYPE_W-1:0] typ;
        logic [19:0]       regs;
        logic [4:0]        wreg;
        logic [31:0]       imm;
        logic [31:0]       pc;
        logic              ill;
    } exp_t;

    exp_t        q[$];
    int          r_tab[64];
    int          o_tab[64];
    int          n_chk = 0;
    int          n_err = 0;
    int          m_cnt = 0;
    logic        m_seen = 1'b0;
    logic [31:0] m_pc = '0;

    int fl[27] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A,
                   'h2B, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08, 'h18,
                   'h19, 'h1A, 'h1B, 'h10, 'h12, 'h11, 'h13, 'h1F, 'h01};
    int ol[16] = '{'h08, 'h09, 'h0C, 'h0D, 'h0E, 'h0F, 'h23, 'h2B,
                   'h04, 'h05, 'h0A, 'h0B, 'h02, 'h03, 'h3F, 'h01};

    function automatic void build_tabs();
        int rf[17] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                       'h2A, 'h2B, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08};
        int op[14] = '{'h08, 'h09, 'h0C, 'h0D, 'h0E, 'h0F, 'h23,
                       'h2B, 'h04, 'h05, 'h0A, 'h0B, 'h02, 'h03};
        for (int i = 0; i < 64; i++) begin
            r_tab[i] = -1;
            o_tab[i] = -1;
        end
        for (int i = 0; i < 17; i++) r_tab[rf[i]] = i;
        for (int i = 0; i < 14; i++) o_tab[op[i]] = 17 + i;
`ifdef ID_EXT_EN
        r_tab['h18] = 31; r_tab['h19] = 32;
        r_tab['h1A] = 33; r_tab['h1B] = 34;
        r_tab['h10] = 35; r_tab['h12] = 36;
        r_tab['h11] = 37; r_tab['h13] = 38;
`endif
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int c;
        c = (w[31:26] == 6'd0) ? r_tab[w[5:0]] : o_tab[w[31:26]];
        e.ill  = (c < 0);
        e.typ  = e.ill ? '0 : (TYPE_W'(1) << c);
        e.regs = w[25:6];
        e.pc   = pc;
        e.wreg = 5'd0;
        if ((c >= 0 && c <= 15) || c == 35 || c == 36) e.wreg = w[15:11];
        else if ((c >= 17 && c <= 23) || c == 27 || c == 28) e.wreg = w[20:16];
        else if (c == 30) e.wreg = 5'd31;
        if (c >= 19 && c <= 21) e.imm = {16'h0, w[15:0]};
        else if (c == 22) e.imm = {w[15:0], 16'h0};
        else if (c == 29 || c == 30) e.imm = {pc[31:28], w[25:0], 2'b00};
        else e.imm = {{16{w[15]}}, w[15:0]};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        bit   push;
        bit   pop;
        if (rst) begin
            q.delete();
            m_cnt  = 0;
            m_seen = 1'b0;
            m_pc   = '0;
        end else begin
            push = in_valid && (q.size() < DEPTH);
            pop  = out_ready && (q.size() > 0);
            e    = model(in_instr, in_pc);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            if (ill_clr) begin
                m_cnt  = 0;
                m_seen = 1'b0;
                m_pc   = '0;
            end else if (push && e.ill) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (!m_seen) begin
                    m_seen = 1'b1;
                    m_pc   = in_pc;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t h;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < DEPTH);
        if (q.size() != 0) begin
            h = q[0];
            chk("head_type", out_type, h.typ);
            chk("head_regs", {out_rs, out_rt, out_rd, out_shamt}, h.regs);
            chk("head_wreg", out_wreg, h.wreg);
            chk("head_imm", out_imm, h.imm);
            chk("head_pc", out_pc, h.pc);
            chk("head_ill", out_ill, h.ill);
        end else begin
            chk("empty_type", out_type, '0);
            chk("empty_imm_pc", {out_imm, out_pc}, '0);
        end
        chk("ill_cnt", ill_cnt, m_cnt);
        chk("ill_seen", ill_seen, m_seen);
        chk("ill_pc", ill_pc, m_pc);
    end

    initial begin
        int sel;
        logic [31:0] r;
        build_tabs();
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_cnt", ill_cnt, 0);

        in_valid = 1'b1; in_instr = 32'h00851020; in_pc = 32'h1000;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_type", out_type, 40'h1);
        chk("t1_wreg", out_wreg, 2);
        chk("t1_ill", out_ill, 0);
        chk("t1_pc", out_pc, 32'h1000);

        in_valid = 1'b1; in_instr = 32'h3C01ABCD; in_pc = 32'h1004;
        tick();
        in_instr = 32'h3021FFFF; in_pc = 32'h1008;
        @(negedge clk);
        chk("t2_lui_imm", out_imm, 32'hABCD0000);
        chk("t2_lui_wreg", out_wreg, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_andi_imm", out_imm, 32'h0000FFFF);
        chk("t2_andi_wreg", out_wreg, 1);
        tick();

        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h34420001; in_pc = 32'h200;
        tick();
        in_pc = 32'h204;
        tick();
        in_pc = 32'h208;
        tick();
        @(negedge clk);
        chk("t3_full_ready", in_ready, 0);
        chk("t3_head0", out_pc, 32'h200);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_hold", out_pc, 32'h200);
        tick();
        @(negedge clk);
        chk("t3_head1", out_pc, 32'h204);
        chk("t3_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_head2", out_pc, 32'h208);
        tick();
        @(negedge clk);
        chk("t3_drained", out_valid, 0);

        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFC000000; in_pc = 32'h100;
        tick();
        in_instr = 32'h0000001F; in_pc = 32'h104;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_cnt", ill_cnt, 2);
        chk("t4_pc", ill_pc, 32'h100);
        chk("t4_seen", ill_seen, 1);
        chk("t4_ill", out_ill, 1);
        chk("t4_type", out_type, 0);
        ill_clr = 1'b1;
        tick();
        ill_clr = 1'b0;
        @(negedge clk);
        chk("t4_clr_cnt", ill_cnt, 0);
        chk("t4_clr_seen", ill_seen, 0);
        out_ready = 1'b1;
        repeat (2) tick();

        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_instr = 32'h00000000 | (i << 11);
            in_pc = 32'h300 + 4 * i;
            tick();
            @(negedge clk);
            chk("t5_valid", out_valid, 1);
            chk("t5_pc", out_pc, 32'h300 + 4 * i);
        end
        in_valid = 1'b0;
        tick();

        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h0C000040; in_pc = 32'h80000000;
        tick();
        in_instr = 32'h00000000; in_pc = 32'h84;
        @(negedge clk);
        chk("t6_type", out_type, 40'h40000000);
        chk("t6_wreg", out_wreg, 31);
        chk("t6_imm", out_imm, 32'h80000100);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);

        in_valid = 1'b1; in_instr = 32'h00000010; in_pc = 32'h400;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
`ifdef ID_EXT_EN
        chk("mfhi_type", out_type, 40'h800000000);
        chk("mfhi_ill", out_ill, 0);
`else
        chk("mfhi_type", out_type, 0);
        chk("mfhi_ill", out_ill, 1);
`endif
        out_ready = 1'b1;
        tick();

        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 2);
            r = $urandom;
            case (sel)
                0: in_instr = {6'd0, r[25:6], 6'(fl[$urandom_range(0, 26)])};
                1: in_instr = {6'(ol[$urandom_range(0, 15)]), r[25:0]};
                default: in_instr = r;
            endcase
            in_pc = $urandom;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ill_clr = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        in_valid = 1'b0; ill_clr = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
